// File: rtl/fetch_ifid_stage.sv
// PC register, next-PC select and IF/ID pipeline register with stall/flush debug counters.
// All outputs registered (1-cycle latency); a redirect overrides both hold enables.
module fetch_ifid_stage #(
  parameter int               XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_Write,
  input  logic             IF_ID_Write,
  input  logic             Branch_Taken,
  input  logic [XLEN-1:0]  Branch_Target,
  input  logic [31:0]      Instr_in,
  output logic [XLEN-1:0]  PC_out,
  output logic [XLEN-1:0]  IFID_PC,
  output logic [31:0]      IFID_Instr,
  output logic             IFID_Valid,
  output logic             Misalign_Flag,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (Branch_Taken) begin
      // Redirect squashes the fetched instruction even when the hazard unit is holding.
      pc_d         = {Branch_Target[XLEN-1:2], 2'b00};
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      if (Branch_Target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else begin
      if (PC_Write) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (IF_ID_Write) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = Instr_in;
        ifid_valid_d = 1'b1;
      end
      if ((!PC_Write || !IF_ID_Write) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign PC_out        = pc_q;
  assign IFID_PC       = ifid_pc_q;
  assign IFID_Instr    = ifid_instr_q;
  assign IFID_Valid    = ifid_valid_q;
  assign Misalign_Flag = misalign_q;
  assign Stall_Count   = stall_cnt_q;
  assign Flush_Count   = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Randomized and directed bench for fetch_ifid_stage against a cycle-level reference model.
module tb_fetch_ifid_stage;

  logic        clk;
  logic        reset;
  logic        PC_Write, IF_ID_Write, Branch_Taken;
  logic [63:0] Branch_Target;
  logic [31:0] Instr_in;
  logic [63:0] PC_out, IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid, Misalign_Flag;
  logic [31:0] Stall_Count, Flush_Count;

  // Second instance: wrapping reset PC and narrow counters.
  logic        rst2;
  logic        pw2, iw2;
  logic [63:0] pc2, ipc2;
  logic [31:0] ins2;
  logic        vld2, mis2;
  logic [3:0]  stall2, flush2;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins, m_stall, m_flush;
  logic        m_vld, m_mis;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0001;
  endfunction

  assign Instr_in = mem(PC_out);

  fetch_ifid_stage dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .Instr_in(Instr_in),
    .PC_out(PC_out), .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid),
    .Misalign_Flag(Misalign_Flag), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  fetch_ifid_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(4)) dut2 (
    .clk(clk), .reset(rst2), .PC_Write(pw2), .IF_ID_Write(iw2),
    .Branch_Taken(1'b0), .Branch_Target(64'h0), .Instr_in(32'hDEAD_BEEF),
    .PC_out(pc2), .IFID_PC(ipc2), .IFID_Instr(ins2), .IFID_Valid(vld2),
    .Misalign_Flag(mis2), .Stall_Count(stall2), .Flush_Count(flush2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_ins = 32'h0000_0013; m_vld = 1'b0;
    m_mis = 1'b0; m_stall = 32'h0; m_flush = 32'h0;
  endtask

  // One clock edge: apply inputs, advance the model by the edge's rules.
  task automatic drive(input logic pw, input logic iw, input logic bt, input logic [63:0] tgt);
    logic [63:0] n_pc, n_ipc;
    logic [31:0] n_ins, n_stall, n_flush;
    logic        n_vld, n_mis;
    #1;
    PC_Write = pw; IF_ID_Write = iw; Branch_Taken = bt; Branch_Target = tgt;
    n_pc = m_pc; n_ipc = m_ipc; n_ins = m_ins; n_vld = m_vld;
    n_mis = m_mis; n_stall = m_stall; n_flush = m_flush;
    if (bt) begin
      n_pc = tgt & ~64'h3;
      n_ipc = 64'h0; n_ins = 32'h0000_0013; n_vld = 1'b0;
      if (tgt[1:0] != 2'b00) n_mis = 1'b1;
      if (m_flush != 32'hFFFF_FFFF) n_flush = m_flush + 1;
    end else begin
      if (pw) n_pc = m_pc + 64'd4;
      if (iw) begin n_ipc = m_pc; n_ins = mem(m_pc); n_vld = 1'b1; end
      if ((!pw || !iw) && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ipc = n_ipc; m_ins = n_ins; m_vld = n_vld;
    m_mis = n_mis; m_stall = n_stall; m_flush = n_flush;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", PC_out, m_pc);
      check("ifid_pc", IFID_PC, m_ipc);
      check("ifid_instr", {32'h0, IFID_Instr}, {32'h0, m_ins});
      check("ifid_valid", {63'h0, IFID_Valid}, {63'h0, m_vld});
      check("misalign", {63'h0, Misalign_Flag}, {63'h0, m_mis});
      check("stall_cnt", {32'h0, Stall_Count}, {32'h0, m_stall});
      check("flush_cnt", {32'h0, Flush_Count}, {32'h0, m_flush});
    end
  end

  initial begin
    reset = 1'b0; rst2 = 1'b0;
    PC_Write = 1'b1; IF_ID_Write = 1'b1; Branch_Taken = 1'b0; Branch_Target = 64'h0;
    pw2 = 1'b1; iw2 = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_pc", PC_out, 64'h0);
    check("rst_instr", {32'h0, IFID_Instr}, 64'h13);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Sequential fetch from reset
    repeat (3) drive(1'b1, 1'b1, 1'b0, 64'h0);
    check("seq_pc_12", PC_out, 64'hC);
    check("seq_ifid_pc_8", IFID_PC, 64'h8);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    check("seq_pc_16", PC_out, 64'h10);

    // Two-cycle load-use hold
    repeat (2) drive(1'b0, 1'b0, 1'b0, 64'h0);
    check("hold_pc", PC_out, 64'h10);
    check("hold_ifid_pc", IFID_PC, 64'hC);
    check("hold_stall", {32'h0, Stall_Count}, 64'd2);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    check("resume_pc", PC_out, 64'h14);

    // Redirect during a hold
    drive(1'b0, 1'b0, 1'b1, 64'h200);
    check("br_pc", PC_out, 64'h200);
    check("br_instr", {32'h0, IFID_Instr}, 64'h13);
    check("br_valid", {63'h0, IFID_Valid}, 64'h0);
    check("br_flush", {32'h0, Flush_Count}, 64'd1);
    check("br_stall", {32'h0, Stall_Count}, 64'd2);

    // Misaligned redirect, then sticky flag
    drive(1'b1, 1'b1, 1'b1, 64'h203);
    check("mis_pc", PC_out, 64'h200);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 64'h0);
    check("mis_sticky", {63'h0, Misalign_Flag}, 64'h1);

    // Randomized traffic, including mismatched enables
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            {$urandom, $urandom});
    end

    // Asynchronous reset mid-stall, between edges
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    PC_Write = 1'b0; IF_ID_Write = 1'b0; Branch_Taken = 1'b0;
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_pc", PC_out, 64'h0);
    check("arst_ifid_pc", IFID_PC, 64'h0);
    check("arst_instr", {32'h0, IFID_Instr}, 64'h13);
    check("arst_valid", {63'h0, IFID_Valid}, 64'h0);
    check("arst_mis", {63'h0, Misalign_Flag}, 64'h0);
    check("arst_stall", {32'h0, Stall_Count}, 64'h0);
    check("arst_flush", {32'h0, Flush_Count}, 64'h0);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (5) drive(1'b1, 1'b1, 1'b0, 64'h0);
    check("post_rst_pc", PC_out, 64'h14);
    chk_en = 1'b0;

    // PC wrap and counter saturation on the narrow instance
    #1 rst2 = 1'b1;
    @(posedge clk);
    #1;
    check("wrap_pc", pc2, 64'h0);
    check("wrap_ifid_pc", ipc2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'h0, ins2}, 64'hDEAD_BEEF);
    pw2 = 1'b0; iw2 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall", {60'h0, stall2}, 64'hF);
    check("sat_pc_held", pc2, 64'h0);
    check("sat_flush", {60'h0, flush2}, 64'h0);
    check("sat_mis", {63'h0, mis2}, 64'h0);
    check("sat_valid", {63'h0, vld2}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
PC register, next-PC logic and IF/ID pipeline register for the 5-stage RISC-V core. This block is the consumer of the load-use hazard controls (PC_Write, IF_ID_Write) and of the EX-stage branch redirect. It drives the instruction-memory address and presents the latched instruction/PC to ID. It also keeps stall and flush event counters for debug.

Parameters:
XLEN, 64, PC / branch-target width in bits
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble encoding inserted into IF/ID (addi x0,x0,0)
CNT_W, 32, width of the stall and flush counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
PC_Write  input  1  1 = PC may update this cycle; 0 = hold PC (load-use stall)
IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents
Branch_Taken  input  1  redirect request from EX (branch/jump resolved taken)
Branch_Target  input  XLEN  redirect address from EX
Instr_in  input  32  instruction-memory read data for address PC_out (combinational memory)
PC_out  output  XLEN  current fetch address (registered)
IFID_PC  output  XLEN  PC of the instruction held in IF/ID
IFID_Instr  output  32  instruction held in IF/ID
IFID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
Misalign_Flag  output  1  sticky: a redirect target had bits [1:0] != 0
Stall_Count  output  CNT_W  cycles in which the hold took effect
Flush_Count  output  CNT_W  number of redirects taken

Behaviour:
- Reset (reset=0, async, no clock needed): PC_out=RESET_PC, IFID_PC=0, IFID_Instr=NOP_INSTR, IFID_Valid=0, Misalign_Flag=0, Stall_Count=0, Flush_Count=0. Reset asserted mid-operation discards all state immediately. First fetch from RESET_PC on the first rising edge after reset is released.
- All state updates occur on the rising clk edge. Outputs are registered, so latency from an input to its visible effect is 1 cycle.
- Priority per edge: (1) Branch_Taken, (2) hold, (3) normal.
- Redirect (Branch_Taken=1): PC_out <= {Branch_Target[XLEN-1:2],2'b00}. IF/ID <= bubble (IFID_Instr=NOP_INSTR, IFID_Valid=0, IFID_PC=0). Flush_Count += 1. Applies regardless of PC_Write/IF_ID_Write, because the stalled instruction is on the wrong path. If Branch_Target[1:0]!=0, set Misalign_Flag=1. Misalign_Flag is cleared only by reset.
- Hold: PC_Write=0 → PC_out unchanged. IF_ID_Write=0 → IFID_* unchanged. The two controls act independently; mismatched values are legal and each register obeys its own enable.
- Stall_Count += 1 on any edge without a redirect where PC_Write=0 or IF_ID_Write=0.
- Normal (PC_Write=1, no redirect): PC_out <= PC_out + 4, modulo 2^XLEN (wraps to 0 from all-ones minus 3).
- Normal (IF_ID_Write=1, no redirect): IFID_Instr <= Instr_in, IFID_PC <= PC_out, IFID_Valid <= 1.
- Both counters saturate at all-ones; they never wrap.
- No combinational path from any input to any output.

Test Plan:
- Reset then release, PC_Write=IF_ID_Write=1, Instr_in=PC-derived pattern → PC_out = 0,4,8,12 on successive edges. IFID_PC lags PC_out by one cycle. IFID_Valid=1 from the 2nd edge. Counters = 0.
- At PC_out=0x10, hold PC_Write=IF_ID_Write=0 for 2 cycles → PC_out stays 0x10 and IFID_PC stays 0x0C for 2 cycles. Stall_Count=2. Fetch resumes at 0x14.
- Branch_Taken=1, Branch_Target=0x200, with PC_Write=IF_ID_Write=0 on the same cycle → next edge gives PC_out=0x200, IFID_Instr=0x00000013, IFID_Valid=0, Flush_Count=1, Stall_Count unchanged.
- Branch_Target=0x203 → PC_out=0x200 and Misalign_Flag=1. Flag stays 1 across 10 further normal cycles and clears only on reset.
- Load RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one normal edge → PC_out=0. Separately, force Stall_Count to saturation (CNT_W=4, hold 20 cycles) → Stall_Count=4'hF.
- Assert reset low between clock edges mid-stall → all outputs take their reset values immediately, with no clock edge required.
